// File: rtl/commit_reorder_unit_if.sv
// Branch-to-retirement handshake bundle for commit_reorder_unit.
// One valid/ready pair per producing branch plus the tagged result payload.
interface commit_reorder_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_BRANCHES = 4,
  parameter int ID_WIDTH   = 9,
  parameter int N_CHANNELS = 16,
  parameter int N_BLOCKS   = 256
);
  logic [N_BRANCHES-1:0]                          in_valid;
  logic [N_BRANCHES-1:0]                          in_ready;
  logic [N_BRANCHES-1:0][$clog2(N_BLOCKS)-1:0]    block_in;
  logic [N_BRANCHES-1:0][2*DATA_WIDTH-1:0]        result;
  logic [N_BRANCHES-1:0][$clog2(N_CHANNELS)-1:0]  dest;
  logic [N_BRANCHES-1:0][ID_WIDTH-1:0]            commit_id;
  logic [N_BRANCHES-1:0]                          commit_flag;

  modport master (
    output in_valid, block_in, result, dest, commit_id, commit_flag,
    input  in_ready
  );

  modport slave (
    input  in_valid, block_in, result, dest, commit_id, commit_flag,
    output in_ready
  );
endinterface

// File: rtl/commit_reorder_unit.sv
// In-order retirement stage for a multi-branch DSP core.
// Results arrive out of order tagged with commit_id, park in a ROB_DEPTH-slot
// window indexed by the low id bits, and retire one per cycle in id order to
// the channel file or the MAC accumulator. A sample_tick steals the channel
// write port for one cycle; frame_start flushes the window.
// Optional build macro COMMIT_BYPASS_EN: an arriving head id retires in the
// same cycle without occupying a slot.
module commit_reorder_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int N_BRANCHES = 4,
  parameter int MAC_BRANCH = 3,
  parameter int ID_WIDTH   = 9,
  parameter int ROB_DEPTH  = 8,
  parameter int N_CHANNELS = 16,
  parameter int N_BLOCKS   = 256
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic                           i_sample_tick,
  input  logic signed [DATA_WIDTH-1:0]   i_sample_in,
  input  logic                           i_frame_start,
  commit_reorder_unit_if.slave           br,
  output logic [$clog2(N_CHANNELS)-1:0]  o_channel_write_addr,
  output logic [DATA_WIDTH-1:0]          o_channel_write_val,
  output logic                           o_channel_write_enable,
  output logic [2*DATA_WIDTH-1:0]        o_accumulator_write_val,
  output logic                           o_accumulator_write_enable,
  output logic                           o_accumulator_add_enable,
  output logic [$clog2(N_BLOCKS)-1:0]    o_commit_block,
  output logic [$clog2(ROB_DEPTH):0]     o_rob_occupancy
);
  localparam int SLOT_W = $clog2(ROB_DEPTH);
  localparam int DEST_W = $clog2(N_CHANNELS);
  localparam int BW     = $clog2(N_BLOCKS);
  localparam int RW     = 2*DATA_WIDTH;
  localparam int OCC_W  = SLOT_W+1;
  localparam logic [ID_WIDTH-1:0] DEPTH_ID = ID_WIDTH'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] r_slot_valid;
  logic [ROB_DEPTH-1:0] r_slot_mac;
  logic [ROB_DEPTH-1:0] r_slot_flag;
  logic [DEST_W-1:0]    r_slot_dest   [ROB_DEPTH];
  logic [RW-1:0]        r_slot_result [ROB_DEPTH];
  logic [BW-1:0]        r_slot_block  [ROB_DEPTH];
  logic [ID_WIDTH-1:0]  r_next_id;
  logic [OCC_W-1:0]     r_occ;

  logic [DEST_W-1:0]     r_ch_addr;
  logic [DATA_WIDTH-1:0] r_ch_val;
  logic                  r_ch_we;
  logic [RW-1:0]         r_acc_val;
  logic                  r_acc_we;
  logic                  r_acc_add;
  logic [BW-1:0]         r_commit_block;

  logic                  w_retire_ok;
  logic                  w_retire;
  logic                  w_bypass;
  logic [SLOT_W-1:0]     w_head_slot;
  logic [ID_WIDTH-1:0]   w_base;
  logic [ID_WIDTH-1:0]   w_dist [N_BRANCHES];
  logic [N_BRANCHES-1:0] w_ready;
  logic [N_BRANCHES-1:0] w_store;
  logic [OCC_W-1:0]      w_n_store;
  logic                  w_ret_mac;
  logic                  w_ret_flag;
  logic [DEST_W-1:0]     w_ret_dest;
  logic [RW-1:0]         w_ret_result;
  logic [BW-1:0]         w_ret_block;

  assign w_head_slot = r_next_id[SLOT_W-1:0];
  assign w_retire_ok = i_enable && !i_sample_tick && !i_frame_start;
  assign w_retire    = w_retire_ok && r_slot_valid[w_head_slot];
  // The window slides before acceptance so a slot freed by retirement can be
  // refilled by id + ROB_DEPTH in the same cycle.
  assign w_base      = w_retire ? r_next_id + ID_WIDTH'(1) : r_next_id;

  for (genvar g = 0; g < N_BRANCHES; g++) begin : g_dist
    assign w_dist[g] = br.commit_id[g] - w_base;
  end

  // Accept in-window ids into free slots; lowest branch index wins a slot clash
  always_comb begin
    logic [ROB_DEPTH-1:0] v_claimed;
    v_claimed = r_slot_valid;
    w_ready   = '0;
    if (w_retire) v_claimed[w_head_slot] = 1'b0;
    for (int i = 0; i < N_BRANCHES; i++) begin
      if (i_enable && !i_frame_start && br.in_valid[i] && (w_dist[i] < DEPTH_ID) &&
          !v_claimed[br.commit_id[i][SLOT_W-1:0]]) begin
        w_ready[i] = 1'b1;
        v_claimed[br.commit_id[i][SLOT_W-1:0]] = 1'b1;
      end
    end
  end

  assign br.in_ready = w_ready;

  // Select the retiring entry (head slot, or a bypassing branch) and the slot writes
  always_comb begin
    w_store      = w_ready;
    w_bypass     = 1'b0;
    w_ret_mac    = r_slot_mac[w_head_slot];
    w_ret_flag   = r_slot_flag[w_head_slot];
    w_ret_dest   = r_slot_dest[w_head_slot];
    w_ret_result = r_slot_result[w_head_slot];
    w_ret_block  = r_slot_block[w_head_slot];
`ifdef COMMIT_BYPASS_EN
    if (w_retire_ok && !r_slot_valid[w_head_slot]) begin
      for (int i = 0; i < N_BRANCHES; i++) begin
        if (w_ready[i] && (br.commit_id[i] == r_next_id)) begin
          w_bypass     = 1'b1;
          w_store[i]   = 1'b0;
          w_ret_mac    = (i == MAC_BRANCH);
          w_ret_flag   = br.commit_flag[i];
          w_ret_dest   = br.dest[i];
          w_ret_result = br.result[i];
          w_ret_block  = br.block_in[i];
        end
      end
    end
`endif
    w_n_store = '0;
    for (int i = 0; i < N_BRANCHES; i++) w_n_store = w_n_store + OCC_W'(w_store[i]);
  end

  // Reorder window storage, head pointer and occupancy
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_slot_valid <= '0;
      r_slot_mac   <= '0;
      r_slot_flag  <= '0;
      for (int s = 0; s < ROB_DEPTH; s++) begin
        r_slot_dest[s]   <= '0;
        r_slot_result[s] <= '0;
        r_slot_block[s]  <= '0;
      end
      r_next_id <= '0;
      r_occ     <= '0;
    end else if (i_frame_start) begin
      r_slot_valid <= '0;
      r_next_id    <= '0;
      r_occ        <= '0;
    end else begin
      if (w_retire) r_slot_valid[w_head_slot] <= 1'b0;
      for (int i = 0; i < N_BRANCHES; i++) begin
        if (w_store[i]) begin
          r_slot_valid[br.commit_id[i][SLOT_W-1:0]]  <= 1'b1;
          r_slot_mac[br.commit_id[i][SLOT_W-1:0]]    <= (i == MAC_BRANCH);
          r_slot_flag[br.commit_id[i][SLOT_W-1:0]]   <= br.commit_flag[i];
          r_slot_dest[br.commit_id[i][SLOT_W-1:0]]   <= br.dest[i];
          r_slot_result[br.commit_id[i][SLOT_W-1:0]] <= br.result[i];
          r_slot_block[br.commit_id[i][SLOT_W-1:0]]  <= br.block_in[i];
        end
      end
      if (w_retire || w_bypass) r_next_id <= r_next_id + ID_WIDTH'(1);
      r_occ <= r_occ + w_n_store - OCC_W'(w_retire);
    end
  end

  // Registered write ports: sample_tick owns the channel port, else the retiring entry
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ch_addr      <= '0;
      r_ch_val       <= '0;
      r_ch_we        <= 1'b0;
      r_acc_val      <= '0;
      r_acc_we       <= 1'b0;
      r_acc_add      <= 1'b0;
      r_commit_block <= '0;
    end else begin
      r_ch_we   <= 1'b0;
      r_acc_we  <= 1'b0;
      r_acc_add <= 1'b0;
      if (!i_frame_start && i_enable && i_sample_tick) begin
        r_ch_addr <= '0;
        r_ch_val  <= i_sample_in;
        r_ch_we   <= 1'b1;
      end else if (w_retire || w_bypass) begin
        if (w_ret_mac) begin
          r_acc_val <= w_ret_result;
          r_acc_we  <= 1'b1;
          r_acc_add <= ~w_ret_flag;
        end else begin
          r_ch_addr <= w_ret_dest;
          r_ch_val  <= w_ret_result[DATA_WIDTH-1:0];
          r_ch_we   <= 1'b1;
        end
        r_commit_block <= w_ret_block;
      end
    end
  end

  assign o_channel_write_addr       = r_ch_addr;
  assign o_channel_write_val        = r_ch_val;
  assign o_channel_write_enable     = r_ch_we;
  assign o_accumulator_write_val    = r_acc_val;
  assign o_accumulator_write_enable = r_acc_we;
  assign o_accumulator_add_enable   = r_acc_add;
  assign o_commit_block             = r_commit_block;
  assign o_rob_occupancy            = r_occ;
endmodule
